inst_queue: RTL and testbench

- FIFO between the fetch stage and the decoder; the producing end of the IF_ID_PACKET interface the decoder consumes.
- Buffers fetched instructions and presents the oldest one as an IF_ID_PACKET.
- Pops on dispatch, flushes on squash, and stops the front end once the decoder flags a halt or illegal instruction at the head.

---
 rtl/inst_queue_pkg.sv | 44 ++++
 rtl/inst_queue_ptr_ctrl.sv | 70 +++++++
 rtl/inst_queue.sv | 117 +++++++++++
 tb/tb_inst_queue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// ============================================================================
//  Module      : inst_queue_pkg
//  Description : Shared fetch/decode types for the instruction queue:
//                XLEN/NOP defines, IF_ID_PACKET, queue entry and state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

// addi x0, x0, 0
`ifndef NOP
`define NOP 32'h00000013
`endif

package inst_queue_pkg;

    localparam logic [31:0] NOP_INST = `NOP;

    // Packet handed from the fetch side to the decoder
    typedef struct packed {
        logic [31:0]       inst;
        logic [`XLEN-1:0]  PC;
        logic [`XLEN-1:0]  NPC;
        logic              valid;
    } IF_ID_PACKET;

    // One buffered instruction
    typedef struct packed {
        logic [31:0]       inst;
        logic [`XLEN-1:0]  PC;
        logic [`XLEN-1:0]  NPC;
    } IQ_ENTRY;

    typedef enum logic {
        IQ_RUN    = 1'b0,
        IQ_HALTED = 1'b1
    } IQ_STATE;

endpackage

`default_nettype wire

// File: rtl/inst_queue_ptr_ctrl.sv
// ============================================================================
//  Module      : iq_ptr_ctrl
//  Description : Head/tail/count bookkeeping for a power-of-two circular
//                queue, with full/empty flags. Clear has priority over
//                push/pop. Callers never push when full or pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_ptr_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [$clog2(DEPTH)-1:0]     head_o,
    output logic [$clog2(DEPTH)-1:0]     tail_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointer/count values; pointers wrap naturally at DEPTH
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    // Pointer/count registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
//  Module      : inst_queue
//  Description : Fetch-to-decode instruction FIFO. Presents the oldest entry
//                as an IF_ID_PACKET, pops on dispatch, flushes on squash and
//                stops accepting fetches once a halting head is dispatched.
//                Optional macro INST_QUEUE_BYPASS_EN lets an empty queue
//                present the fetch inputs combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fetch_valid,
    input  logic [31:0]                 fetch_inst,
    input  logic [`XLEN-1:0]            fetch_pc,
    input  logic [`XLEN-1:0]            fetch_npc,
    output logic                        fetch_ready,
    output IF_ID_PACKET                 if_packet,
    input  logic                        dispatch_en,
    input  logic                        decode_halt,
    input  logic                        squash,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        halted
);

    localparam int PW = $clog2(DEPTH);

    IQ_STATE       state_q, state_d;
    IQ_ENTRY       mem_q [DEPTH];

    logic [PW-1:0] head, tail;
    logic          full, empty;
    logic          run, head_valid, bypass, out_valid;
    logic          push, pop, halt_go, clear;

    assign run        = (state_q == IQ_RUN);
    assign head_valid = reset & run & ~empty;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass     = reset & run & empty & fetch_valid;
`else
    assign bypass     = 1'b0;
`endif

    assign out_valid   = head_valid | bypass;
    assign fetch_ready = reset & run & ~full;
    // A bypassed instruction that is dispatched in the same cycle is never stored
    assign push        = fetch_valid & fetch_ready & ~(bypass & dispatch_en);
    assign pop         = dispatch_en & head_valid;
    assign halt_go     = dispatch_en & out_valid & decode_halt;
    // Halting discards whatever is still queued behind the halting instruction
    assign clear       = squash | halt_go;
    assign halted      = (state_q == IQ_HALTED);

    iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Entry storage: write the fetched instruction at the tail
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail] <= '{inst: fetch_inst, PC: fetch_pc, NPC: fetch_npc};
        end
    end

    // Decoder packet: bypassed fetch, queued head, or a NOP bubble
    always_comb begin
        if_packet       = '0;
        if_packet.inst  = NOP_INST;
        if (bypass) begin
            if_packet.inst  = fetch_inst;
            if_packet.PC    = fetch_pc;
            if_packet.NPC   = fetch_npc;
            if_packet.valid = 1'b1;
        end else if (head_valid) begin
            if_packet.inst  = mem_q[head].inst;
            if_packet.PC    = mem_q[head].PC;
            if_packet.NPC   = mem_q[head].NPC;
            if_packet.valid = 1'b1;
        end
    end

    // Run/halt state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IQ_RUN;
        else        state_q <= state_d;
    end

    // Next state: halt on a dispatched halting head; squash always restarts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IQ_RUN:    if (halt_go) state_d = IQ_HALTED;
            IQ_HALTED: state_d = IQ_HALTED;
            default:   state_d = IQ_RUN;
        endcase
        if (squash) state_d = IQ_RUN;
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Self-checking bench for inst_queue (DEPTH=8): reset checks,
//                a vector table, corner-case sequences and a randomized run
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] WFI = 32'h10500073;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               fetch_valid;
    logic [31:0]        fetch_inst;
    logic [`XLEN-1:0]   fetch_pc;
    logic [`XLEN-1:0]   fetch_npc;
    logic               fetch_ready;
    IF_ID_PACKET        if_packet;
    logic               dispatch_en;
    logic               decode_halt;
    logic               squash;
    logic [CW-1:0]      count;
    logic               halted;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_npc   (fetch_npc),
        .fetch_ready (fetch_ready),
        .if_packet   (if_packet),
        .dispatch_en (dispatch_en),
        .decode_halt (decode_halt),
        .squash      (squash),
        .count       (count),
        .halted      (halted)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[11:0], 20'h00093};   // addi x1, x0, pc[11:0]
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0; fetch_npc = '0;
        dispatch_en = 1'b0; decode_halt = 1'b0; squash = 1'b0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic [31:0] inst);
        fetch_valid = 1'b1; fetch_pc = pc; fetch_npc = pc + 32'd4; fetch_inst = inst;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    // Full visible-state check; head entry assumed to hold inst_of(pc), npc=pc+4
    task automatic chk_state(input string tag, input int ecnt, input bit erdy,
                             input bit evld, input logic [31:0] epc, input bit ehalt);
        #1;
        chk({tag, ".count"}, 64'(count), 64'(ecnt));
        chk({tag, ".ready"}, 64'(fetch_ready), 64'(erdy));
        chk({tag, ".valid"}, 64'(if_packet.valid), 64'(evld));
        chk({tag, ".halted"}, 64'(halted), 64'(ehalt));
        chk({tag, ".pc"}, 64'(if_packet.PC), evld ? 64'(epc) : 64'd0);
        chk({tag, ".npc"}, 64'(if_packet.NPC), evld ? 64'(epc + 32'd4) : 64'd0);
        chk({tag, ".inst"}, 64'(if_packet.inst), evld ? 64'(inst_of(epc)) : 64'(32'h00000013));
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          de;
        bit          dh;
        bit          sq;
        int          ecnt;
        bit          erdy;
        bit          evld;
        logic [31:0] epc;
        bit          ehalt;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    vec_t vt[14];
    ent_t mq[$];
    bit   mhalt;

    initial begin
        idle();
        // Expected state after each row's edge, inputs returned to idle
        vt[0]  = '{1, 32'h100, 0, 0, 0, 1, 1, 1, 32'h100, 0};
        vt[1]  = '{1, 32'h104, 0, 0, 0, 2, 1, 1, 32'h100, 0};
        vt[2]  = '{1, 32'h108, 1, 0, 0, 2, 1, 1, 32'h104, 0};
        vt[3]  = '{0, 32'h0,   1, 0, 0, 1, 1, 1, 32'h108, 0};
        vt[4]  = '{0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h0,   0};
        vt[5]  = '{0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h0,   0};
        vt[6]  = '{1, 32'h10C, 0, 0, 0, 1, 1, 1, 32'h10C, 0};
        vt[7]  = '{1, 32'h110, 0, 0, 0, 2, 1, 1, 32'h10C, 0};
        vt[8]  = '{1, 32'h120, 1, 0, 1, 0, 1, 0, 32'h0,   0};
        vt[9]  = '{1, 32'h114, 0, 0, 0, 1, 1, 1, 32'h114, 0};
        vt[10] = '{0, 32'h0,   1, 1, 0, 0, 0, 0, 32'h0,   1};
        vt[11] = '{1, 32'h124, 0, 0, 0, 0, 0, 0, 32'h0,   1};
        vt[12] = '{0, 32'h0,   0, 0, 1, 0, 1, 0, 32'h0,   0};
        vt[13] = '{1, 32'h118, 0, 0, 0, 1, 1, 1, 32'h118, 0};

        // ---- reset state (reset held low) ----
        #2;
        chk("rst.ready", 64'(fetch_ready), 64'd0);
        chk("rst.valid", 64'(if_packet.valid), 64'd0);
        chk("rst.inst", 64'(if_packet.inst), 64'(32'h00000013));
        chk("rst.pc", 64'(if_packet.PC), 64'd0);
        chk("rst.npc", 64'(if_packet.NPC), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.halted", 64'(halted), 64'd0);

        // ---- vector table ----
        do_reset();
        chk_state("post_rst", 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            idle();
            if (vt[i].fv) set_fetch(vt[i].pc, inst_of(vt[i].pc));
            dispatch_en = vt[i].de; decode_halt = vt[i].dh; squash = vt[i].sq;
            tick();
            idle();
            chk_state($sformatf("vec%0d", i), vt[i].ecnt, vt[i].erdy, vt[i].evld, vt[i].epc, vt[i].ehalt);
        end

        // ---- fill to full, then drain in order ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_fetch(32'(i*4), inst_of(32'(i*4)));
            tick();
        end
        idle();
        chk_state("full", 8, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            dispatch_en = 1'b1;
            #1;
            chk($sformatf("drain%0d.pc", i), 64'(if_packet.PC), 64'(i*4));
            tick();
        end
        idle();
        chk_state("drained", 0, 1, 0, 0, 0);

        // ---- simultaneous enqueue/dequeue across the wrap ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_fetch(32'(i*4), inst_of(32'(i*4)));
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            set_fetch(32'(12 + 4*k), inst_of(32'(12 + 4*k)));
            dispatch_en = 1'b1;
            #1;
            chk($sformatf("sim%0d.count", k), 64'(count), 64'd3);
            chk($sformatf("sim%0d.pc", k), 64'(if_packet.PC), 64'(4*k));
            tick();
        end
        idle();
        chk_state("sim_end", 3, 1, 1, 32'h28, 0);

        // ---- halt on wfi at head ----
        do_reset();
        set_fetch(32'h200, WFI); tick();
        for (int i = 1; i < 4; i++) begin
            set_fetch(32'h200 + 32'(4*i), inst_of(32'h200 + 32'(4*i)));
            tick();
        end
        idle();
        #1;
        chk("halt.head_inst", 64'(if_packet.inst), 64'(WFI));
        dispatch_en = 1'b1; decode_halt = 1'b1;
        tick();
        idle();
        chk_state("halted", 0, 0, 0, 0, 1);
        set_fetch(32'h300, inst_of(32'h300));
        tick();
        idle();
        chk_state("halted_hold", 0, 0, 0, 0, 1);
        squash = 1'b1;
        tick();
        idle();
        chk_state("unhalt", 0, 1, 0, 0, 0);

        // ---- squash beats enqueue/dequeue ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_fetch(32'(i*4), inst_of(32'(i*4)));
            tick();
        end
        set_fetch(32'h80, inst_of(32'h80));
        dispatch_en = 1'b1; squash = 1'b1;
        tick();
        idle();
        chk_state("squash", 0, 1, 0, 0, 0);
        tick();
        chk_state("squash_after", 0, 1, 0, 0, 0);

        // ---- asynchronous reset between edges ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_fetch(32'(i*4), inst_of(32'(i*4)));
            tick();
        end
        idle();
        #1;
        chk("arst.pre_count", 64'(count), 64'd6);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.valid", 64'(if_packet.valid), 64'd0);
        chk("arst.ready", 64'(fetch_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

`ifdef INST_QUEUE_BYPASS_EN
        // ---- bypass: empty queue, fetch consumed in the same cycle ----
        do_reset();
        set_fetch(32'h40, 32'h00500093);
        dispatch_en = 1'b1;
        #1;
        chk("byp.valid", 64'(if_packet.valid), 64'd1);
        chk("byp.inst", 64'(if_packet.inst), 64'(32'h00500093));
        chk("byp.pc", 64'(if_packet.PC), 64'h40);
        chk("byp.count", 64'(count), 64'd0);
        tick();
        idle();
        chk_state("byp_after", 0, 1, 0, 0, 0);
`endif

        // ---- randomized run against a queue model ----
        do_reset();
        mq.delete();
        mhalt = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bit   e_rdy, e_vld, byp;
            ent_t hd;
            fetch_valid = ($urandom_range(0, 9) < 7);
            fetch_pc    = {$urandom_range(0, 1023), 2'b00};
            fetch_npc   = $urandom;
            fetch_inst  = $urandom;
            dispatch_en = $urandom_range(0, 1);
            decode_halt = ($urandom_range(0, 15) == 0);
            squash      = ($urandom_range(0, 24) == 0);
            #1;
            e_rdy = !mhalt && (mq.size() < DEPTH);
            e_vld = !mhalt && (mq.size() > 0);
            byp   = 1'b0;
            hd    = '{inst: 32'h00000013, pc: 32'h0, npc: 32'h0};
            if (e_vld) hd = mq[0];
`ifdef INST_QUEUE_BYPASS_EN
            if (!mhalt && mq.size() == 0 && fetch_valid) begin
                byp   = 1'b1;
                e_vld = 1'b1;
                hd    = '{inst: fetch_inst, pc: fetch_pc, npc: fetch_npc};
            end
`endif
            chk("rnd.ready", 64'(fetch_ready), 64'(e_rdy));
            chk("rnd.valid", 64'(if_packet.valid), 64'(e_vld));
            chk("rnd.inst", 64'(if_packet.inst), 64'(hd.inst));
            chk("rnd.pc", 64'(if_packet.PC), 64'(hd.pc));
            chk("rnd.npc", 64'(if_packet.NPC), 64'(hd.npc));
            chk("rnd.count", 64'(count), 64'(mq.size()));
            chk("rnd.halted", 64'(halted), 64'(mhalt));
            if (squash) begin
                mq.delete();
                mhalt = 1'b0;
            end else if (e_vld && dispatch_en && decode_halt) begin
                mq.delete();
                mhalt = 1'b1;
            end else begin
                if (e_vld && dispatch_en && !byp) void'(mq.pop_front());
                if (fetch_valid && e_rdy && !(byp && dispatch_en))
                    mq.push_back('{inst: fetch_inst, pc: fetch_pc, npc: fetch_npc});
            end
            tick();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
